// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared stage indices and address type for the CPU core
package cpu_pkg;

   localparam int STAGE_PC  = 0;
   localparam int STAGE_IF  = 1;
   localparam int STAGE_ID  = 2;
   localparam int STAGE_EX  = 3;
   localparam int STAGE_MEM = 4;
   localparam int STAGE_WB  = 5;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/prio_enc_msb.sv
// rtl/prio_enc_msb.sv - highest-set-bit priority encoder with valid flag
module prio_enc_msb #(
   parameter int W = 8
) (
   input  logic [W-1:0]                          req,
   output logic [((W > 1) ? $clog2(W) : 1)-1:0]  idx,
   output logic                                  valid
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;

   // Later iterations overwrite earlier ones, so the highest set bit wins.
   always_comb begin
      idx   = '0;
      valid = |req;
      for (int i = 0; i < W; i++) begin
         if (req[i]) begin
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with held redirects and deadlock watch
module pipe_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int NUM_STAGES = 6,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_STAGES-1:0]        stall_req_i,
   input  logic [NUM_STAGES-1:0]        flush_req_i,
   input  logic [NUM_STAGES*ADDR_W-1:0] flush_tgt_i,
   output logic [NUM_STAGES-1:0]        stall_o,
   output logic [NUM_STAGES-1:0]        flush_o,
   output logic                         pc_redirect_o,
   output logic [ADDR_W-1:0]            pc_target_o,
   output logic [CNT_W-1:0]             stall_cnt_o,
   output logic                         deadlock_o
);

   localparam int SW = $clog2(NUM_STAGES);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic [NUM_STAGES-1:0] stall_raw;
   logic [NUM_STAGES-1:0] bubble;
   logic [NUM_STAGES-1:0] kill;
   logic [NUM_STAGES-1:0] flush_raw;
   logic [NUM_STAGES-1:0] enc_req;

   logic [SW-1:0]         sel_idx;
   logic                  sel_valid;
   logic                  new_take;
   logic                  cand_valid;
   logic [SW-1:0]         cand_src;
   logic [ADDR_W-1:0]     new_tgt;
   logic [ADDR_W-1:0]     cand_tgt;
   logic                  apply_c;

   logic                  pend_valid;
   logic [SW-1:0]         pend_src;
   logic [ADDR_W-1:0]     pend_tgt;
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      run_cnt;
   logic                  deadlock;

   // An older stage stalling freezes every younger stage behind it.
   always_comb begin
      logic acc;
      acc       = 1'b0;
      stall_raw = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         acc          = acc | stall_req_i[i];
         stall_raw[i] = acc;
      end
   end

   assign enc_req = {flush_req_i[NUM_STAGES-1:1], 1'b0};

   prio_enc_msb #(
      .W     (NUM_STAGES)
   ) u_redirect_sel (
      .req   (enc_req),
      .idx   (sel_idx),
      .valid (sel_valid)
   );

   always_comb begin
      new_tgt = '0;
      for (int i = STAGE_IF; i < NUM_STAGES; i++) begin
         if (sel_idx == SW'(i)) begin
            new_tgt = flush_tgt_i[i*ADDR_W +: ADDR_W];
         end
      end

      // A new request only displaces the held one if it comes from an older stage.
      new_take   = sel_valid && (!pend_valid || (sel_idx > pend_src));
      cand_valid = new_take || pend_valid;
      cand_src   = new_take ? sel_idx : pend_src;
      cand_tgt   = new_take ? new_tgt : pend_tgt;
      apply_c    = cand_valid && !stall_raw[cand_src];

      bubble = '0;
      kill   = '0;
      for (int i = STAGE_IF; i < NUM_STAGES; i++) begin
         bubble[i] = stall_raw[i-1] & ~stall_raw[i];
         kill[i]   = apply_c && (SW'(i) <= cand_src);
      end
      flush_raw = (bubble | kill) & ~stall_raw;
   end

   assign stall_o       = rst_n ? stall_raw : '0;
   assign flush_o       = rst_n ? flush_raw : {{(NUM_STAGES-1){1'b1}}, 1'b0};
   assign pc_redirect_o = rst_n && apply_c;
   assign pc_target_o   = (rst_n && apply_c) ? cand_tgt : '0;
   assign stall_cnt_o   = stall_cnt;
   assign deadlock_o    = deadlock;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_src   <= '0;
         pend_tgt   <= '0;
         stall_cnt  <= '0;
         run_cnt    <= '0;
         deadlock   <= 1'b0;
      end else begin
         if (apply_c) begin
            pend_valid <= 1'b0;
         end else if (cand_valid) begin
            pend_valid <= 1'b1;
            pend_src   <= cand_src;
            pend_tgt   <= cand_tgt;
         end

         if (stall_raw[0] && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end

         if (!stall_raw[0]) begin
            run_cnt <= '0;
         end else if (run_cnt != TIMEOUT_C) begin
            run_cnt <= run_cnt + 1'b1;
         end

         if (stall_raw[0] && (run_cnt == TIMEOUT_C - 1'b1)) begin
            deadlock <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   import cpu_pkg::*;

   localparam int N  = 6;
   localparam int AW = 32;
   localparam int CW = 16;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    stall_req;
   logic [N-1:0]    flush_req;
   logic [N*AW-1:0] flush_tgt;
   logic [N-1:0]    stall;
   logic [N-1:0]    flush;
   logic            pc_redirect;
   logic [AW-1:0]   pc_target;
   logic [CW-1:0]   stall_cnt;
   logic            deadlock;

   int checks;
   int errors;

   pipe_hazard_ctrl #(
      .NUM_STAGES (N),
      .ADDR_W     (AW),
      .CNT_W      (CW),
      .TIMEOUT    (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_req_i   (stall_req),
      .flush_req_i   (flush_req),
      .flush_tgt_i   (flush_tgt),
      .stall_o       (stall),
      .flush_o       (flush),
      .pc_redirect_o (pc_redirect),
      .pc_target_o   (pc_target),
      .stall_cnt_o   (stall_cnt),
      .deadlock_o    (deadlock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_tgt(input int s, input addr_t v);
      flush_tgt[s*AW +: AW] = v;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      stall_req = '1;
      flush_req = '1;
      flush_tgt = '1;
      #1;
      chk("rst_stall", stall, 6'b000000);
      chk("rst_flush", flush, 6'b111110);
      chk("rst_redir", pc_redirect, 1'b0);
      chk("rst_tgt", pc_target, 32'h0);
      step();
      chk("rst_cnt", stall_cnt, 16'd0);
      chk("rst_dead", deadlock, 1'b0);
      rst_n     = 1'b1;
      stall_req = '0;
      flush_req = '0;
      flush_tgt = '0;
      settle();
      chk("idle_redir", pc_redirect, 1'b0);

      stall_req = 6'b000100;
      settle();
      chk("st_stall", stall, 6'b000111);
      chk("st_flush", flush, 6'b001000);
      step();
      stall_req = '0;
      settle();
      chk("st0_stall", stall, 6'b000000);
      chk("st0_flush", flush, 6'b000000);
      chk("st_cnt1", stall_cnt, 16'd1);

      set_tgt(3, 32'h8000_0100);
      flush_req = 6'b001000;
      settle();
      chk("rd_flush", flush, 6'b001110);
      chk("rd_redir", pc_redirect, 1'b1);
      chk("rd_tgt", pc_target, 32'h8000_0100);
      step();
      flush_req = '0;
      settle();
      chk("rd_done", pc_redirect, 1'b0);

      stall_req = 6'b010000;
      set_tgt(3, 32'h200);
      flush_req = 6'b001000;
      settle();
      chk("hold_redir1", pc_redirect, 1'b0);
      chk("hold_stall", stall, 6'b011111);
      chk("hold_flush", flush, 6'b100000);
      step();
      flush_req = '0;
      settle();
      chk("hold_redir2", pc_redirect, 1'b0);
      step();
      chk("hold_redir3", pc_redirect, 1'b0);
      step();
      stall_req = '0;
      settle();
      chk("rel_flush", flush, 6'b001110);
      chk("rel_redir", pc_redirect, 1'b1);
      chk("rel_tgt", pc_target, 32'h200);
      step();
      chk("rel_done", pc_redirect, 1'b0);
      chk("cnt4", stall_cnt, 16'd4);
      chk("no_dead", deadlock, 1'b0);

      stall_req = 6'b010000;
      set_tgt(2, 32'h300);
      flush_req = 6'b000100;
      settle();
      chk("ovr_redir1", pc_redirect, 1'b0);
      step();
      set_tgt(4, 32'h400);
      flush_req = 6'b010000;
      settle();
      chk("ovr_redir2", pc_redirect, 1'b0);
      step();
      set_tgt(1, 32'h500);
      flush_req = 6'b000010;
      settle();
      chk("ovr_redir3", pc_redirect, 1'b0);
      step();
      flush_req = '0;
      stall_req = '0;
      settle();
      chk("ovr_tgt", pc_target, 32'h400);
      chk("ovr_flush", flush, 6'b011110);
      chk("ovr_redir", pc_redirect, 1'b1);
      step();
      chk("ovr_done", pc_redirect, 1'b0);

      stall_req = 6'b000010;
      set_tgt(3, 32'h600);
      flush_req = 6'b001000;
      settle();
      chk("pri_stall", stall, 6'b000011);
      chk("pri_flush", flush, 6'b001100);
      chk("pri_redir", pc_redirect, 1'b1);
      chk("pri_tgt", pc_target, 32'h600);
      step();
      stall_req = '0;
      flush_req = '0;
      settle();
      chk("pri_done", pc_redirect, 1'b0);
      chk("cnt8", stall_cnt, 16'd8);

      rst_n = 1'b0;
      step();
      rst_n     = 1'b1;
      stall_req = 6'b000001;
      settle();
      chk("dl_cnt0", stall_cnt, 16'd0);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("dl_flag%0d", k), deadlock, (k >= 4) ? 1'b1 : 1'b0);
      end
      chk("dl_cnt5", stall_cnt, 16'd5);
      stall_req = '0;
      step();
      chk("dl_sticky", deadlock, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      settle();
      chk("dl_rst_cnt", stall_cnt, 16'd0);
      chk("dl_rst_flag", deadlock, 1'b0);

      stall_req = 6'b010000;
      set_tgt(3, 32'h900);
      flush_req = 6'b001000;
      step();
      rst_n     = 1'b0;
      stall_req = '1;
      flush_req = '1;
      settle();
      chk("rp_stall", stall, 6'b000000);
      chk("rp_flush", flush, 6'b111110);
      chk("rp_redir", pc_redirect, 1'b0);
      chk("rp_tgt", pc_target, 32'h0);
      step();
      rst_n     = 1'b1;
      stall_req = '0;
      flush_req = '0;
      settle();
      chk("rp_after_redir", pc_redirect, 1'b0);
      chk("rp_after_flush", flush, 6'b000000);
      chk("rp_after_tgt", pc_target, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
